struct_reg_rr_arbiter: RTL

- Round-robin arbiter and sequencer for one shared packed-struct register with fields d0 and d1. This is the configuration resource that generic packages in this codebase expose as a struct type.
- N requesters compete for ownership. Only the owner's field values are written into the shared register.
- Sits between per-channel config agents and the single struct instance consumed downstream.

---
 rtl/struct_reg_rr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/struct_reg_rr_arbiter.sv
// Round-robin ownership arbiter for one shared {d0,d1} struct register.
// Define STRUCT_REG_ARB_PREEMPT_EN to enable hold-time preemption of the owner.
module struct_reg_rr_arbiter #(
    parameter int N        = 4,
    parameter int D0_W     = 1,
    parameter int D1_W     = 2,
    parameter int MAX_HOLD = 8,
    localparam int GW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N-1:0]        i_req,
    input  logic [N-1:0]        i_lock,
    input  logic [N*D0_W-1:0]   i_d0,
    input  logic [N*D1_W-1:0]   i_d1,
    output logic [N-1:0]        o_gnt,
    output logic [GW-1:0]       o_gnt_id,
    output logic [D0_W-1:0]     o_d0,
    output logic [D1_W-1:0]     o_d1,
    output logic                o_busy,
    output logic                o_timeout
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gnt_id_q, gnt_id_d;
    logic [GW-1:0]     last_id_q, last_id_d;
    logic [D0_W-1:0]   d0_q, d0_d;
    logic [D1_W-1:0]   d1_q, d1_d;
    logic              timeout_q, timeout_d;
    logic [GW-1:0]     sel;
    logic              found;
    logic              preempt;

    // First requester at or after the slot following the previous owner.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && i_req[(int'(last_id_q) + 1 + k) % N]) begin
                found = 1'b1;
                sel   = GW'((int'(last_id_q) + 1 + k) % N);
            end
        end
    end

`ifdef STRUCT_REG_ARB_PREEMPT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  others_req;

    always_comb begin
        others_req = i_req;
        others_req[gnt_id_q] = 1'b0;
        preempt = (state_q == OWN) && i_req[gnt_id_q] && !i_lock[gnt_id_q] &&
                  (hold_q == HW'(MAX_HOLD)) && (|others_req);
    end

    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE) begin
            hold_d = '0;
        end else if (i_req[gnt_id_q] && !preempt && hold_q != HW'(MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    localparam int unused_max_hold = MAX_HOLD;
    logic unused_lock;
    assign unused_lock = ^i_lock;
    assign preempt     = 1'b0;
`endif

    // A release or preemption always passes through IDLE before the next grant.
    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = OWN;
                    gnt_id_d  = sel;
                    last_id_d = sel;
                end
            end
            OWN: begin
                if (!i_req[gnt_id_q]) begin
                    state_d = IDLE;
                end else if (preempt) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    d0_d = i_d0[int'(gnt_id_q) * D0_W +: D0_W];
                    d1_d = i_d1[int'(gnt_id_q) * D1_W +: D1_W];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            last_id_q <= GW'(N - 1);
            d0_q      <= '0;
            d1_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        o_gnt = '0;
        if (state_q == OWN) o_gnt[gnt_id_q] = 1'b1;
    end

    assign o_gnt_id  = gnt_id_q;
    assign o_busy    = (state_q == OWN);
    assign o_d0      = d0_q;
    assign o_d1      = d1_q;
    assign o_timeout = timeout_q;

endmodule
